// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc 8-bit processor: opcodes, sequencer
// state encoding and ULA operation width.
package nrisc_pkg;

    localparam int ULA_OP_W = 3;

    localparam logic [2:0] OP_ADDI  = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUBI  = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } estado_t;

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle control sequencer for nRisc: steps the shared datapath through
// fetch/decode/exec/mem/writeback and counts retired instructions.
module controle_multiciclo
    import nrisc_pkg::*;
#(
    parameter int CONT_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [2:0]          Opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_src,
    output logic                ula_src,
    output logic [ULA_OP_W-1:0] ula_op,
    output logic                halted,
    output logic [2:0]          estado,
    output logic [CONT_W-1:0]   instr_count
);

    estado_t state, next_state;
    logic    retire;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    assign estado = state;

    // Memory handshake: a request (mem_read/mem_write) is held steady from the
    // first cycle of FETCH/MEM; the access completes on the cycle mem_ready is
    // high. mem_ready is not looked at in any other state.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_src    = 1'b0;
        ula_src    = 1'b0;
        ula_op     = '0;
        halted     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (Opcode == OP_HALT) begin
                    retire     = 1'b1;
                    next_state = ST_HALT;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ula_op = Opcode;
                case (Opcode)
                    OP_LW, OP_SW: next_state = ST_MEM;
                    OP_JMP: begin
                        pc_write   = 1'b1;
                        pc_src     = 1'b1;
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end
                    OP_BEQ: begin
                        pc_write   = zero;
                        pc_src     = 1'b1;
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end
                    default: begin
                        // ALU class: only the register-register form uses rs2
                        ula_src    = (Opcode != OP_ADD);
                        next_state = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                ula_op = Opcode;
                if (Opcode == OP_SW) mem_write = 1'b1;
                else                 mem_read  = 1'b1;
                if (mem_ready) begin
                    if (Opcode == OP_SW) begin
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_src    = (Opcode == OP_LW);
                retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction cycle traces are built from
// the opcode rules, then replayed cycle by cycle against the DUT outputs.
module tb_controle_multiciclo;
    import nrisc_pkg::*;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    Opcode = 3'b000;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          ir_write, pc_write, pc_src, mem_read, mem_write;
    logic          reg_write, reg_src, ula_src, halted;
    logic [2:0]    ula_op, estado;
    logic [CW-1:0] instr_count;

    controle_multiciclo #(.CONT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .Opcode(Opcode),
        .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_src(reg_src),
        .ula_src(ula_src), .ula_op(ula_op), .halted(halted),
        .estado(estado), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] est;
        logic irw, pcw, pcs, mr, mw, rw, rs, us;
        logic [2:0] uop;
        logic hlt;
    } out_t;

    typedef struct {
        logic [2:0] op;
        logic rdy, z, st;
        out_t exp;
        logic retire;
    } cyc_t;

    cyc_t          plan[$];
    logic [CW-1:0] exp_cnt = '0;
    int            checks = 0;
    int            failures = 0;
    string         cur_test = "none";

    function automatic out_t blank(input logic [2:0] est);
        out_t o = '0;
        o.est = est;
        return o;
    endfunction

    function automatic out_t observed();
        out_t o;
        o.est = estado; o.irw = ir_write; o.pcw = pc_write; o.pcs = pc_src;
        o.mr = mem_read; o.mw = mem_write; o.rw = reg_write; o.rs = reg_src;
        o.us = ula_src; o.uop = ula_op; o.hlt = halted;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [2:0] op, input logic rdy, input logic z,
                        input logic st, input out_t e, input logic retire);
        cyc_t c;
        c.op = op; c.rdy = rdy; c.z = z; c.st = st; c.exp = e; c.retire = retire;
        plan.push_back(c);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push(3'($urandom_range(0, 7)), rbit(), rbit(), 1'b0, blank(ST_IDLE), 1'b0);
        push(3'($urandom_range(0, 7)), rbit(), rbit(), 1'b1, blank(ST_IDLE), 1'b0);
    endtask

    // One instruction from FETCH to retirement, derived from the opcode class rules
    task automatic add_instr(input logic [2:0] op, input int fst, input int mst, input logic z);
        out_t e;
        logic is_alu, is_mem;
        is_alu = (op == 3'b000) || (op == 3'b011) || (op == 3'b100);
        is_mem = (op == 3'b001) || (op == 3'b010);
        for (int i = 0; i < fst; i++) begin
            e = blank(ST_FETCH); e.mr = 1'b1;
            push(3'($urandom_range(0, 7)), 1'b0, rbit(), rbit(), e, 1'b0);
        end
        e = blank(ST_FETCH); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push(3'($urandom_range(0, 7)), 1'b1, rbit(), rbit(), e, 1'b0);
        push(op, rbit(), rbit(), rbit(), blank(ST_DECODE), op == 3'b111);
        if (op == 3'b111) return;
        e = blank(ST_EXEC); e.uop = op;
        if (is_alu) e.us = (op != 3'b011);
        if (op == 3'b101) begin e.pcw = 1'b1; e.pcs = 1'b1; end
        if (op == 3'b110) begin e.pcw = z; e.pcs = 1'b1; end
        push(op, rbit(), z, rbit(), e, !is_alu && !is_mem);
        if (is_mem) begin
            e = blank(ST_MEM); e.uop = op;
            e.mr = (op == 3'b001); e.mw = (op == 3'b010);
            for (int i = 0; i < mst; i++) push(op, 1'b0, rbit(), rbit(), e, 1'b0);
            push(op, 1'b1, rbit(), rbit(), e, op == 3'b010);
        end
        if (is_alu || op == 3'b001) begin
            e = blank(ST_WB); e.rw = 1'b1; e.rs = (op == 3'b001);
            push(op, rbit(), rbit(), rbit(), e, 1'b1);
        end
    endtask

    task automatic add_halt(input int n);
        out_t e;
        e = blank(ST_HALT); e.hlt = 1'b1;
        for (int i = 0; i < n; i++) push(3'b111, rbit(), rbit(), rbit(), e, 1'b0);
    endtask

    // Replay up to n planned cycles: drive after the edge, compare mid-cycle
    task automatic run_plan(input int n);
        cyc_t c;
        out_t o;
        for (int i = 0; i < n && plan.size() > 0; i++) begin
            c = plan.pop_front();
            @(posedge clock); #1;
            Opcode = c.op; mem_ready = c.rdy; zero = c.z; start = c.st;
            #3;
            o = observed();
            checks++;
            if (o !== c.exp) begin
                failures++;
                $display("FAIL %s outputs got=%h exp=%h (est %0d vs %0d)", cur_test, o, c.exp, o.est, c.exp.est);
            end
            checks++;
            if (instr_count !== exp_cnt) begin
                failures++;
                $display("FAIL %s instr_count got=%0d exp=%0d", cur_test, instr_count, exp_cnt);
            end
            if (c.retire) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic do_reset();
        out_t o;
        plan.delete();
        @(posedge clock); #1;
        reset_n = 1'b0; start = rbit(); mem_ready = rbit();
        @(posedge clock); #1;
        start = rbit(); mem_ready = rbit(); Opcode = 3'($urandom_range(0, 7));
        #3;
        o = observed();
        checks++;
        if (o !== blank(ST_IDLE)) begin
            failures++;
            $display("FAIL %s reset_outputs got=%h exp=%h", cur_test, o, blank(ST_IDLE));
        end
        checks++;
        if (instr_count !== '0) begin
            failures++;
            $display("FAIL %s reset_count got=%0d exp=0", cur_test, instr_count);
        end
        exp_cnt = '0;
        reset_n = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        do_reset();
        add_idle(2);
        run_plan(plan.size());
    endtask

    task automatic test_alu();
        cur_test = "alu";
        add_instr(3'b000, 0, 0, 1'b0);
        add_instr(3'b011, 0, 0, rbit());
        add_instr(3'b100, 1, 0, rbit());
        run_plan(plan.size());
    endtask

    task automatic test_load_stall();
        cur_test = "load_stall";
        add_instr(3'b001, 0, 2, rbit());
        run_plan(plan.size());
    endtask

    task automatic test_beq();
        cur_test = "beq";
        add_instr(3'b110, 0, 0, 1'b1);
        add_instr(3'b110, 0, 0, 1'b0);
        add_instr(3'b101, 0, 0, rbit());
        run_plan(plan.size());
    endtask

    task automatic test_store_fetch_stall();
        cur_test = "store_stall";
        add_instr(3'b010, 3, 0, rbit());
        add_instr(3'b010, 0, 2, rbit());
        run_plan(plan.size());
    endtask

    task automatic test_random();
        logic [2:0] op;
        cur_test = "random";
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 6));
            add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end
        run_plan(plan.size());
    endtask

    task automatic test_halt();
        cur_test = "halt";
        add_instr(3'b111, 1, 0, rbit());
        add_halt(8);
        run_plan(plan.size());
        do_reset();
        add_idle(1);
        add_instr(3'b000, 0, 0, rbit());
        run_plan(plan.size());
    endtask

    task automatic test_reset_mid_stall();
        cur_test = "reset_mid_stall";
        add_instr(3'b001, 0, 6, rbit());
        run_plan(5);
        do_reset();
        add_idle(1);
        add_instr(3'b010, 0, 1, rbit());
        run_plan(plan.size());
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_stall();
        test_beq();
        test_store_fetch_stall();
        test_random();
        test_halt();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
